// File: rtl/fp_addsub_arb_pkg.sv
// Shared definitions for the two-requester FP add/sub arbiter and its datapath.
// Holds the FSM encoding, op/rounding-mode constants and a leading-zero helper.
package fp_addsub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Returns 27 for an all-zero input.
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_add_sub.sv
// Combinational IEEE-754 single-precision adder/subtractor with five rounding modes.
// Uses guard/round/sticky alignment; NaN results are the canonical quiet NaN.
module fp_add_sub
    import fp_addsub_arb_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        op_i,
    input  logic [2:0]  rm_i,
    output logic [31:0] result_o
);

    logic [31:0] b_eff;
    logic [31:0] x;
    logic [31:0] y;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        swap;
    logic        eff_sub;
    logic        sign;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  dexp;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] my_sh;
    logic        sticky;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [9:0]  lsh;
    logic [26:0] norm;
    logic [23:0] mant;
    logic        grd;
    logic        rnd_st;
    logic        inc;
    logic [24:0] mant_r;
    logic [23:0] mant_f;
    logic        ovf_inf;

    always_comb begin
        b_eff = {b_i[31] ^ (op_i == OP_SUB), b_i[30:0]};
        a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
        a_inf = (a_i[30:0] == 31'h7F80_0000);
        b_inf = (b_i[30:0] == 31'h7F80_0000);

        // Order by magnitude so the aligned difference is never negative.
        swap  = b_eff[30:0] > a_i[30:0];
        x     = swap ? b_eff : a_i;
        y     = swap ? a_i : b_eff;
        ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        dexp  = ex - ey;
        mx    = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        my    = {(y[30:23] != 8'd0), y[22:0], 3'b000};

        sticky = 1'b0;
        if (dexp >= 8'd27) begin
            my_sh = {26'd0, |my};
        end else begin
            my_sh     = my >> dexp;
            sticky    = |(my & ~({27{1'b1}} << dexp));
            my_sh[0]  = my_sh[0] | sticky;
        end

        eff_sub = x[31] ^ y[31];
        sign    = x[31];
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});

        e   = {2'b00, ex};
        lz  = clz27(sum[26:0]);
        lsh = 10'd0;
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'd1;
        end else begin
            // Stop normalising at the minimum exponent; what remains is subnormal.
            lsh  = ({5'd0, lz} < (e - 10'd1)) ? {5'd0, lz} : (e - 10'd1);
            norm = sum[26:0] << lsh;
            e    = e - lsh;
        end

        mant   = norm[26:3];
        grd    = norm[2];
        rnd_st = |norm[1:0];
        case (rm_i)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (grd | rnd_st);
            RM_RUP:  inc = ~sign & (grd | rnd_st);
            RM_RMM:  inc = grd;
            default: inc = grd & (rnd_st | mant[0]);
        endcase

        mant_r = {1'b0, mant} + {24'd0, inc};
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            e      = e + 10'd1;
        end else begin
            mant_f = mant_r[23:0];
        end

        ovf_inf = (rm_i == RM_RNE) || (rm_i == RM_RMM) || (rm_i > RM_RMM) ||
                  ((rm_i == RM_RUP) && !sign) || ((rm_i == RM_RDN) && sign);

        if (a_nan || b_nan) begin
            result_o = CANON_NAN;
        end else if (a_inf && b_inf && (a_i[31] != b_eff[31])) begin
            result_o = CANON_NAN;
        end else if (a_inf) begin
            result_o = a_i;
        end else if (b_inf) begin
            result_o = b_eff;
        end else if (sum == 28'd0) begin
            result_o = {(eff_sub ? (rm_i == RM_RDN) : sign), 31'd0};
        end else if (e >= 10'd255) begin
            result_o = ovf_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
        end else begin
            result_o = {sign, (mant_f[23] ? e[7:0] : 8'd0), mant_f[22:0]};
        end
    end

endmodule

// File: rtl/fp_addsub_arb.sv
// Shares one fp_add_sub datapath between two requesters (IDLE -> EXEC -> RESP).
// Define FP_ADDSUB_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module fp_addsub_arb
    import fp_addsub_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_rm0,
    input  logic [2:0]  req_rm1,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;
    logic        grant_id;
    logic        accept;
    logic [31:0] dp_result;

`ifdef FP_ADDSUB_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        grant_id = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    end
`else
    always_comb begin
        grant_id = ~req_valid[0];
    end
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rm_d      = rm_q;
        id_d      = id_q;
        result_d  = result_q;
        req_ready = 2'b00;
        accept    = 1'b0;
`ifdef FP_ADDSUB_ARB_RR_EN
        ptr_d     = ptr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    req_ready = 2'b01 << grant_id;
                end
                accept = |(req_valid & req_ready);
                if (accept) begin
                    a_d     = grant_id ? req_a1 : req_a0;
                    b_d     = grant_id ? req_b1 : req_b0;
                    op_d    = req_op[grant_id];
                    rm_d    = grant_id ? req_rm1 : req_rm0;
                    id_d    = grant_id;
                    state_d = EXEC;
`ifdef FP_ADDSUB_ARB_RR_EN
                    ptr_d   = ~grant_id;
`endif
                end
            end
            EXEC: begin
                result_d = dp_result;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so a response being aborted is never offered to the consumer.
    assign resp_valid  = (state_q == RESP) && !rst;
    assign resp_id     = id_q;
    assign resp_result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= OP_ADD;
            rm_q     <= RM_RNE;
            id_q     <= 1'b0;
            result_q <= 32'd0;
`ifdef FP_ADDSUB_ARB_RR_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            id_q     <= id_d;
            result_q <= result_d;
`ifdef FP_ADDSUB_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    fp_add_sub u_fp_add_sub (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .rm_i     (rm_q),
        .result_o (dp_result)
    );

endmodule

// File: tb/tb_fp_addsub_arb.sv
// Self-checking bench for fp_addsub_arb: directed handshake/arbitration steps plus
// random operands checked against an exact-arithmetic IEEE-754 reference.
module tb_fp_addsub_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op;
    logic [2:0]  req_rm0, req_rm1;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_addsub_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_op      (req_op),
        .req_rm0     (req_rm0),
        .req_rm1     (req_rm1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact magnitude in units of 2^-149 (the smallest subnormal).
    function automatic logic [299:0] mag_of(input logic [31:0] v);
        logic [299:0] m;
        if (v[30:23] == 8'd0) begin
            m = 300'(v[22:0]);
        end else begin
            m = 300'({1'b1, v[22:0]});
            m = m << (int'(v[30:23]) - 1);
        end
        return m;
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic op, input logic [2:0] rm);
        logic [31:0]  bb;
        logic [299:0] ma, mb, m, one, rem, half, keep;
        logic         sign, inc, to_inf;
        int           p, sh, bexp;
        bb = {b[31] ^ op, b[30:0]};
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC0_0000;
        if (a[30:0] == 31'h7F80_0000 && bb[30:0] == 31'h7F80_0000 && a[31] != bb[31])
            return 32'h7FC0_0000;
        if (a[30:0] == 31'h7F80_0000) return a;
        if (bb[30:0] == 31'h7F80_0000) return bb;
        ma = mag_of(a);
        mb = mag_of(bb);
        if (a[31] == bb[31]) begin
            m = ma + mb; sign = a[31];
        end else if (ma >= mb) begin
            m = ma - mb; sign = a[31];
        end else begin
            m = mb - ma; sign = bb[31];
        end
        if (m == 0) return (a[31] == bb[31]) ? {a[31], 31'd0} : {(rm == 3'd2), 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p <= 23) return {sign, m[30:0]};
        sh   = p - 23;
        one  = 300'd1;
        keep = m >> sh;
        rem  = m & ((one << sh) - one);
        half = one << (sh - 1);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sign && (rem != 0);
            3'd3:    inc = !sign && (rem != 0);
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && keep[0]);
        endcase
        keep = keep + 300'(inc);
        if (keep[24]) begin
            keep = keep >> 1;
            sh++;
        end
        bexp = sh + 1;
        if (bexp >= 255) begin
            to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd3 && !sign) ||
                     (rm == 3'd2 && sign);
            return to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
        end
        return {sign, 8'(bexp), keep[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                case ($urandom_range(0, 5))
                    0: v = 32'h0000_0000;
                    1: v = 32'h8000_0000;
                    2: v = 32'h7F80_0000;
                    3: v = 32'hFF80_0000;
                    4: v = 32'h7FC0_0000;
                    default: v = 32'h0080_0000;
                endcase
            end
            1: v[30:23] = 8'd0;
            2: v[30:23] = 8'(254 - $urandom_range(0, 2));
            default: v[30:23] = 8'(100 + $urandom_range(0, 50));
        endcase
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single-requester transaction with optional response backpressure.
    task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [2:0] rm, input int hold,
                         output logic [31:0] got);
        logic [31:0] exp_res;
        logic [1:0]  me;
        me      = (who == 0) ? 2'b01 : 2'b10;
        exp_res = ref_add(a, b, op, rm);
        if (who == 0) begin
            req_a0 = a; req_b0 = b; req_op[0] = op; req_rm0 = rm;
        end else begin
            req_a1 = a; req_b1 = b; req_op[1] = op; req_rm1 = rm;
        end
        req_valid  = me;
        resp_ready = 1'b0;
        #1;
        check("grant", 32'(req_ready), 32'(me));
        tick();
        req_valid = 2'b00;
        #1;
        check("exec_valid", 32'(resp_valid), 32'd0);
        check("exec_ready", 32'(req_ready), 32'd0);
        tick();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_result", resp_result, exp_res);
        check("resp_id", 32'(resp_id), 32'(who));
        for (int i = 0; i < hold; i++) begin
            req_valid = ~me;
            tick();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_result", resp_result, exp_res);
            check("hold_id", 32'(resp_id), 32'(who));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        got        = resp_result;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("handshake", 32'(resp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_resp(input string tag);
        int c;
        c = 0;
        while (!resp_valid && c < 10) begin
            tick();
            c++;
        end
        check(tag, 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a, b;
        logic [31:0] tab_a [9];
        logic [31:0] tab_b [9];
        logic        tab_op [9];
        logic [2:0]  tab_rm [9];
        logic [31:0] tab_exp [9];
        int          exp_id;

        tab_a = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h4040_0000, 32'h0000_0001,
                  32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h7FC0_0000};
        tab_b = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h4040_0000, 32'h0000_0001,
                  32'h3380_0000, 32'h3380_0000, 32'h0000_0001, 32'h3F80_0000};
        tab_op  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab_rm  = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0};
        tab_exp = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC0_0000, 32'h8000_0000, 32'h0000_0002,
                    32'h3F80_0000, 32'h3F80_0001, 32'h007F_FFFF, 32'h7FC0_0000};

        rst        = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op = 2'b00; req_rm0 = 3'd0; req_rm1 = 3'd0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        req_valid = 2'b00;
        rst       = 1'b0;
        tick();

        do_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 0, got);
        check("add_const", got, 32'h4040_0000);
        do_op(1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 3'd0, 0, got);
        check("sub_const", got, 32'h4000_0000);
        do_op(0, 32'h4120_0000, 32'h3F80_0000, 1'b0, 3'd0, 5, got);
        check("bp_const", got, 32'h4130_0000);

        for (int k = 0; k < 9; k++) begin
            do_op(k % 2, tab_a[k], tab_b[k], tab_op[k], tab_rm[k], 0, got);
            check("edge_const", got, tab_exp[k]);
        end

        // Both requesters held valid for four operations.
        do_reset();
        req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000; req_op[0] = 1'b0; req_rm0 = 3'd0;
        req_a1 = 32'h4040_0000; req_b1 = 32'h3F80_0000; req_op[1] = 1'b1; req_rm1 = 3'd0;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_resp("tie_valid");
`ifdef FP_ADDSUB_ARB_RR_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            check("tie_id", 32'(resp_id), 32'(exp_id));
            check("tie_result", resp_result, (exp_id == 1) ? 32'h4000_0000 : 32'h4040_0000);
            tick();
        end
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        tick();

        // Reset during EXEC aborts the operation and restores the priority pointer.
        do_reset();
        req_a0 = 32'h3F80_0000; req_b0 = 32'h3F80_0000; req_op[0] = 1'b0;
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale", 32'(resp_valid), 32'd0);
        end
        req_valid = 2'b11;
        #1;
        check("ptr_reset", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        wait_resp("abort_next_valid");
        check("abort_next_id", 32'(resp_id), 32'd0);
        check("abort_next_res", resp_result, 32'h4000_0000);
        tick();
        resp_ready = 1'b0;

        for (int k = 0; k < 60; k++) begin
            a = rnd_fp();
            if ($urandom_range(0, 2) == 0) begin
                b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
            end else begin
                b = rnd_fp();
            end
            do_op(int'($urandom_range(0, 1)), a, b, 1'($urandom), 3'($urandom_range(0, 4)),
                  int'($urandom_range(0, 2)), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_addsub_arb.md
FP_ADDSUB_ARB -- requirements
Module: fp_addsub_arb

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 2.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  bit i = requester i has an operation pending.
REQ-006 req_ready  output  2  bit i = requester i's operation is accepted this cycle.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  32 each  IEEE-754 single operands per requester.
REQ-008 req_op  input  2  bit i: 0 = add, 1 = sub, for requester i.
REQ-009 req_rm0, req_rm1  input  3 each  rounding mode per requester.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_id  output  1  index of the requester that owns the result.
REQ-013 resp_result  output  32  IEEE-754 single result.

Function
REQ-014 The block SHALL share one fp_add_sub datapath between two requesters via an FSM with states IDLE, EXEC, RESP.
REQ-015 In IDLE, the block SHALL assert exactly one req_ready bit, for the arbitration winner, and only when that requester's req_valid is high; with no req_valid bit high, req_ready SHALL be 2'b00.
REQ-016 Handshake: acceptance = req_valid[i] & req_ready[i]; on acceptance, the block SHALL register operands, op, rm and id, then move IDLE->EXEC.
REQ-017 In EXEC, the block SHALL register the datapath output into resp_result and move EXEC->RESP; EXEC lasts exactly 1 cycle.
REQ-018 In RESP, resp_valid SHALL be 1; resp_result and resp_id SHALL be stable until resp_valid & resp_ready, which SHALL move RESP->IDLE.
REQ-019 Latency: with acceptance at edge N, resp_valid SHALL rise after edge N+2; at most one operation SHALL be in flight; the next acceptance SHALL occur no earlier than the cycle after the response handshake.
REQ-020 req_ready SHALL be 2'b00 in EXEC and RESP.
REQ-021 With both req_valid bits high, the winner SHALL follow the priority rule of REQ-027/028.
REQ-022 A req_valid that drops before acceptance SHALL simply be not granted; no state SHALL be retained for it.
REQ-023 Special-case and rounding behaviour SHALL be entirely that of fp_add_sub; the block SHALL NOT alter result bits.

Reset
REQ-024 On rst: state = IDLE, resp_valid = 0, resp_result = 32'h0, resp_id = 0, req_ready = 2'b00, and priority pointer = requester 0.
REQ-025 rst asserted in EXEC or RESP SHALL abort the operation; the result SHALL NOT be delivered.

Configuration
REQ-026 The feature SHALL be controlled by macro FP_ADDSUB_ARB_RR_EN.
REQ-027 With FP_ADDSUB_ARB_RR_EN defined: round-robin; the priority pointer SHALL move to the other requester after each acceptance.
REQ-028 Without FP_ADDSUB_ARB_RR_EN: fixed priority; requester 0 SHALL always win a tie, and no pointer register SHALL exist.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and constants OP_ADD=1'b0 and OP_SUB=1'b1.
REQ-030 The block SHALL instantiate fp_add_sub unchanged as its single sub-module; operand muxing and the FSM SHALL be local.

Verification
REQ-031 Add: req 0 with a=32'h3F800000, b=32'h40000000, op=0, rm=0 -> resp_result=32'h40400000, resp_id=0, resp_valid 2 cycles after acceptance.
REQ-032 Sub: req 1 with a=32'h40400000, b=32'h3F800000, op=1 -> resp_result=32'h40000000, resp_id=1.
REQ-033 Tie: both valid continuously, 4 operations -> RR_EN ids 0,1,0,1; without RR_EN ids 0,0,0,0.
REQ-034 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_result and resp_id stable, req_ready=2'b00, single handshake on release.
REQ-035 Reset in EXEC: rst pulsed 1 cycle -> next cycle IDLE, resp_valid=0, pointer=0, no stale response after.
